// File: rtl/mul_seq_shift_add.sv
// mul_seq_shift_add
//   Sequential unsigned shift-add multiplier. Each RUN cycle does one
//   conditional N-bit add of the multiplicand into the high half and then a
//   one-bit right shift of the whole partial product. After N RUN cycles the
//   2N-bit product is loaded into the output register.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start_i; product_o holds the previous result
//   RUN   | one add/shift step per clock, N steps total
//   DONE  | one-cycle done_o pulse with product_o valid
//
// Ports
//   clk_i      rising-edge clock
//   rst_ni     synchronous active-low reset
//   start_i    operation request, accepted only in IDLE
//   a_i        multiplicand, sampled on an accepted start
//   b_i        multiplier, sampled on an accepted start
//   busy_o     high from the cycle after acceptance through the DONE cycle
//   done_o     single-cycle pulse, product_o valid
//   product_o  2N-bit result, stable until the next operation completes

module mul_seq_shift_add #(
    parameter int unsigned N = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [N-1:0]     a_i,
    input  logic [N-1:0]     b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [2*N-1:0]   product_o
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2*N-1:0]  product_q, product_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // {carry, HI} after the conditional add. The carry lands in HI's MSB on
    // the shift in the same cycle, so it never needs its own flop.
    logic [N:0]      sum;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        count_d   = count_q;
        product_d = product_q;
        sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mcand_d = a_i;
                    hi_d    = '0;
                    lo_d    = b_i;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                hi_d    = sum[N:1];
                lo_d    = {sum[0], lo_q[N-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == COUNT_LAST) begin
                    product_d = {sum[N:1], sum[0], lo_q[N-1:1]};
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake outputs come straight from flops, decoded from next state.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;

endmodule

// File: tb/tb_mul_seq_shift_add.sv
// tb_mul_seq_shift_add
//   Self-checking bench for mul_seq_shift_add. Expected products come from
//   plain a*b; expected timing comes from the start/busy/done handshake
//   (done N cycles after acceptance, busy N+1 cycles, done one cycle wide).
//   A second instance with N=4 runs its own random sweep.

module tb_mul_seq_shift_add;

    localparam int unsigned N  = 8;
    localparam int unsigned N4 = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [N-1:0]    a, b;
    logic            busy, done;
    logic [2*N-1:0]  product;

    logic            start4;
    logic [N4-1:0]   a4, b4;
    logic            busy4, done4;
    logic [2*N4-1:0] product4;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*N-1:0]  last_prod;
    logic [2*N4-1:0] last_prod4;

    always #5 clk = ~clk;

    mul_seq_shift_add #(.N(N)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .a_i       (a),
        .b_i       (b),
        .busy_o    (busy),
        .done_o    (done),
        .product_o (product)
    );

    mul_seq_shift_add #(.N(N4)) dut4 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start4),
        .a_i       (a4),
        .b_i       (b4),
        .busy_o    (busy4),
        .done_o    (done4),
        .product_o (product4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [N-1:0] av, input logic [N-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        step();
        start = 1'b0;
    endtask

    // Called right after the acceptance edge; waits for done and checks
    // latency, busy width, pulse width, result and output stability.
    task automatic finish_op(input string tag, input logic [2*N-1:0] exp);
        int cyc = 0;
        int busy_cnt = 0;
        while (!done && cyc < 30) begin
            if (busy) busy_cnt++;
            check({tag, "_stable"}, 32'(product), 32'(last_prod));
            step();
            cyc++;
        end
        if (busy) busy_cnt++;
        check({tag, "_latency"}, 32'(cyc), 32'(N));
        check({tag, "_prod"}, 32'(product), 32'(exp));
        last_prod = exp;
        step();
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'(N + 1));
        check({tag, "_held"}, 32'(product), 32'(last_prod));
    endtask

    task automatic op4(input logic [N4-1:0] av, input logic [N4-1:0] bv);
        int cyc = 0;
        logic [2*N4-1:0] exp;
        exp    = 8'(av * bv);
        start4 = 1'b1;
        a4     = av;
        b4     = bv;
        step();
        start4 = 1'b0;
        a4     = 4'(~av);
        b4     = 4'(~bv);
        while (!done4 && cyc < 20) begin
            check("n4_stable", 32'(product4), 32'(last_prod4));
            step();
            cyc++;
        end
        check("n4_latency", 32'(cyc), 32'(N4));
        check("n4_prod", 32'(product4), 32'(exp));
        last_prod4 = exp;
        step();
        check("n4_pulse", 32'(done4), 32'd0);
    endtask

    initial begin
        int idle_done;
        logic [N-1:0] ra, rb;

        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        last_prod  = '0;
        last_prod4 = '0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_prod", 32'(product), 32'd0);
        check("rst_prod4", 32'(product4), 32'd0);

        launch(8'd13, 8'd11);
        finish_op("d13x11", 16'h008F);

        launch(8'hFF, 8'hFF);
        finish_op("dFFxFF", 16'hFE01);

        launch(8'h00, 8'hA5);
        finish_op("d0xA5", 16'h0000);
        launch(8'hA5, 8'h00);
        finish_op("dA5x0", 16'h0000);

        // start held through RUN/DONE with new operands: must not be queued
        // nor accepted on the DONE edge, only at the next IDLE edge.
        launch(8'd3, 8'd5);
        start = 1'b1;
        a     = 8'd7;
        b     = 8'd7;
        finish_op("hold_first", 16'h000F);
        step();
        start = 1'b0;
        a     = 8'd1;
        b     = 8'd1;
        finish_op("hold_second", 16'h0031);

        // Reset in the middle of RUN aborts with no done pulse.
        launch(8'd200, 8'd100);
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_prod", 32'(product), 32'd0);
        last_prod = '0;
        idle_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) idle_done++;
            step();
        end
        check("abort_no_done", 32'(idle_done), 32'd0);
        launch(8'd200, 8'd100);
        finish_op("after_abort", 16'h4E20);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i % 50 == 0) ra = 8'hFF;
            if (i % 70 == 0) rb = 8'hFF;
            launch(ra, rb);
            a = 8'($urandom);
            b = 8'($urandom);
            finish_op("rand", 16'(ra * rb));
        end

        for (int i = 0; i < 200; i++) begin
            op4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        op4(4'hF, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
